pc_src_ctrl: RTL and testbench

- Control-side producer of the 3-bit PC-source select and the PC write enable for the OTTER multicycle core.
- Runs the fetch/execute/writeback/interrupt sequencing and resolves branch conditions from the branch comparator flags.
- Arbitrates interrupt entry, and drives the select code that the PC mux and PC register consume each cycle.

---
 rtl/otter_pkg.sv | 49 ++++
 rtl/pc_src_ctrl_if.sv | 33 +++
 rtl/branch_cond_gen.sv | 26 ++
 rtl/pc_src_ctrl.sv | 123 ++++++++++++
 tb/tb_pc_src_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER definitions: opcodes, PC-source select codes, branch FUNC3 codes, control FSM state.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package otter_pkg;

   typedef enum logic [6:0] {
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_BRANCH = 7'b1100011,
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_OP_IMM = 7'b0010011,
      OPC_OP     = 7'b0110011,
      OPC_SYSTEM = 7'b1110011
   } opcode_t;

   typedef enum logic [2:0] {
      PC_NEXT   = 3'd0,
      PC_JALR   = 3'd1,
      PC_BRANCH = 3'd2,
      PC_JAL    = 3'd3,
      PC_INTR   = 3'd4
   } pc_src_t;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef logic [1:0] state_t;
   localparam state_t ST_FETCH = 2'd0;
   localparam state_t ST_EXEC  = 2'd1;
   localparam state_t ST_WB    = 2'd2;
   localparam state_t ST_INTR  = 2'd3;

   // True for every opcode the core implements; anything else is illegal.
   function automatic logic is_known_opcode(input logic [6:0] opc);
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
         OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_SYSTEM: is_known_opcode = 1'b1;
         default:                                             is_known_opcode = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/pc_src_ctrl_if.sv
// Control/datapath bundle between the OTTER datapath and the PC-source controller.
// Latency: none (wires only).
// Backpressure: none; every signal is valid every cycle.
// Ports: OPCODE/FUNC3/BR_* /INTR/MIE flow datapath->controller, PC_SOURCE/PC_WRITE/MEM_RE1/MEM_RE2/INT_TAKEN/ILLEGAL flow back.
interface pc_src_ctrl_if #(
   parameter int PC_SRC_W = 3
);
   logic [6:0]          OPCODE;
   logic [2:0]          FUNC3;
   logic                BR_EQ;
   logic                BR_LT;
   logic                BR_LTU;
   logic                INTR;
   logic                MIE;
   logic [PC_SRC_W-1:0] PC_SOURCE;
   logic                PC_WRITE;
   logic                MEM_RE1;
   logic                MEM_RE2;
   logic                INT_TAKEN;
   logic                ILLEGAL;

   // Datapath side.
   modport master (
      output OPCODE, FUNC3, BR_EQ, BR_LT, BR_LTU, INTR, MIE,
      input  PC_SOURCE, PC_WRITE, MEM_RE1, MEM_RE2, INT_TAKEN, ILLEGAL
   );

   // Controller side.
   modport slave (
      input  OPCODE, FUNC3, BR_EQ, BR_LT, BR_LTU, INTR, MIE,
      output PC_SOURCE, PC_WRITE, MEM_RE1, MEM_RE2, INT_TAKEN, ILLEGAL
   );
endinterface

// File: rtl/branch_cond_gen.sv
// Branch-taken resolution from FUNC3 and the comparator flags.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: func3, br_eq, br_lt, br_ltu in; taken out (0 for the unused FUNC3 codes 010/011).
module branch_cond_gen
   import otter_pkg::*;
(
   input  logic [2:0] func3,
   input  logic       br_eq,
   input  logic       br_lt,
   input  logic       br_ltu,
   output logic       taken
);
   always_comb begin
      taken = 1'b0;
      case (func3)
         F3_BEQ:  taken = br_eq;
         F3_BNE:  taken = !br_eq;
         F3_BLT:  taken = br_lt;
         F3_BGE:  taken = !br_lt;
         F3_BLTU: taken = br_ltu;
         F3_BGEU: taken = !br_ltu;
         default: taken = 1'b0;
      endcase
   end
endmodule

// File: rtl/pc_src_ctrl.sv
// OTTER multicycle sequencer: fetch/exec/writeback/interrupt FSM driving PC_SOURCE and PC_WRITE.
// Latency: non-load 2 cycles, load 3 cycles, interrupt entry adds 1 cycle.
// Backpressure: none; outputs are valid every cycle and forced to 0 while RST is high.
// Ports: CLK, RST (sync, active-high), bus (pc_src_ctrl_if.slave).
// Build option: define ILLEGAL_TRAP_EN to trap unrecognised opcodes / BRANCH FUNC3 010,011 into ST_INTR.
module pc_src_ctrl
   import otter_pkg::*;
#(
   parameter int PC_SRC_W  = 3,
   parameter bit SYNC_INTR = 1'b1
) (
   input  logic          CLK,
   input  logic          RST,
   pc_src_ctrl_if.slave  bus
);

   state_t    state;
   state_t    state_nxt;
   logic [1:0] sync_q;
   logic      intr_s;
   logic      pending;
   logic      br_taken;
   logic      trap;

   pc_src_t   src;
   logic      pc_write;
   logic      mem_re1;
   logic      mem_re2;
   logic      int_taken;
   logic      illegal;

   branch_cond_gen u_branch_cond_gen (
      .func3  (bus.FUNC3),
      .br_eq  (bus.BR_EQ),
      .br_lt  (bus.BR_LT),
      .br_ltu (bus.BR_LTU),
      .taken  (br_taken)
   );

   // INTR is asynchronous to CLK unless the integrator guarantees otherwise.
   always_ff @(posedge CLK) begin
      if (RST) sync_q <= 2'b00;
      else     sync_q <= {sync_q[0], bus.INTR};
   end

   assign intr_s = SYNC_INTR ? sync_q[1] : bus.INTR;

   // Clear has priority: the request that triggered entry is consumed in ST_INTR,
   // and a still-asserted INTR only re-arms once software re-enables MIE.
   always_ff @(posedge CLK) begin
      if (RST)                    pending <= 1'b0;
      else if (state == ST_INTR)  pending <= 1'b0;
      else if (intr_s && bus.MIE) pending <= 1'b1;
   end

`ifdef ILLEGAL_TRAP_EN
   assign trap = !is_known_opcode(bus.OPCODE) ||
                 ((bus.OPCODE == OPC_BRANCH) && (bus.FUNC3[2:1] == 2'b01));
`else
   assign trap = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      src       = PC_NEXT;
      pc_write  = 1'b0;
      mem_re1   = 1'b0;
      mem_re2   = 1'b0;
      int_taken = 1'b0;
      illegal   = 1'b0;
      case (state)
         ST_FETCH: begin
            mem_re1   = 1'b1;
            state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            if (bus.OPCODE == OPC_LOAD) begin
               // Load finishes in ST_WB so it is never split by an interrupt.
               mem_re2   = 1'b1;
               state_nxt = ST_WB;
            end else if (trap) begin
               illegal   = 1'b1;
               state_nxt = ST_INTR;
            end else begin
               pc_write = 1'b1;
               case (bus.OPCODE)
                  OPC_JAL:    src = PC_JAL;
                  OPC_JALR:   src = PC_JALR;
                  OPC_BRANCH: src = br_taken ? PC_BRANCH : PC_NEXT;
                  default:    src = PC_NEXT;
               endcase
               state_nxt = pending ? ST_INTR : ST_FETCH;
            end
         end
         ST_WB: begin
            pc_write  = 1'b1;
            state_nxt = pending ? ST_INTR : ST_FETCH;
         end
         ST_INTR: begin
            // Any jump/branch target was already loaded in ST_EXEC; the vector overrides it.
            src       = PC_INTR;
            pc_write  = 1'b1;
            int_taken = 1'b1;
            state_nxt = ST_FETCH;
         end
         default: state_nxt = ST_FETCH;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= ST_FETCH;
      else     state <= state_nxt;
   end

   // Gate on RST so an instruction caught mid-flight never writes the PC.
   assign bus.PC_SOURCE = RST ? '0 : PC_SRC_W'(src);
   assign bus.PC_WRITE  = !RST && pc_write;
   assign bus.MEM_RE1   = !RST && mem_re1;
   assign bus.MEM_RE2   = !RST && mem_re2;
   assign bus.INT_TAKEN = !RST && int_taken;
   assign bus.ILLEGAL   = !RST && illegal;

endmodule

// File: tb/tb_pc_src_ctrl.sv
// Directed bench for pc_src_ctrl: reset, ALU/jump sequencing, branch sweep, loads, interrupts, illegal opcodes.
// Latency: n/a.
// Backpressure: n/a.
module tb_pc_src_ctrl;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   pc_src_ctrl_if #(.PC_SRC_W(3)) bus ();

   pc_src_ctrl #(.PC_SRC_W(3), .SYNC_INTR(1'b0)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // {PC_SOURCE[2:0], PC_WRITE, MEM_RE1, MEM_RE2, INT_TAKEN, ILLEGAL}
   logic [7:0] obs;
   assign obs = {bus.PC_SOURCE, bus.PC_WRITE, bus.MEM_RE1, bus.MEM_RE2, bus.INT_TAKEN, bus.ILLEGAL};

   localparam logic [7:0] O_ZERO  = 8'b000_0_0_0_0_0;
   localparam logic [7:0] O_FETCH = 8'b000_0_1_0_0_0;
   localparam logic [7:0] O_LDEX  = 8'b000_0_0_1_0_0;
   localparam logic [7:0] O_WB    = 8'b000_1_0_0_0_0;
   localparam logic [7:0] O_INTR  = 8'b100_1_0_0_1_0;
   localparam logic [7:0] O_TRAP  = 8'b000_0_0_0_0_1;
   localparam logic [7:0] O_EX0   = 8'b000_1_0_0_0_0;
   localparam logic [7:0] O_EXJR  = 8'b001_1_0_0_0_0;
   localparam logic [7:0] O_EXBR  = 8'b010_1_0_0_0_0;
   localparam logic [7:0] O_EXJAL = 8'b011_1_0_0_0_0;

   localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
   localparam logic [6:0] JALR = 7'b1100111, BRANCH = 7'b1100011, LOAD = 7'b0000011;
   localparam logic [6:0] STORE = 7'b0100011, OPIMM = 7'b0010011, OP = 7'b0110011;
   localparam logic [6:0] SYSTEM = 7'b1110011, BADOP = 7'b1111111;

   logic [6:0] b2b_op  [8] = '{OP, JALR, JAL, LUI, AUIPC, STORE, OPIMM, SYSTEM};
   logic [7:0] b2b_exp [8] = '{O_EX0, O_EXJR, O_EXJAL, O_EX0, O_EX0, O_EX0, O_EX0, O_EX0};

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset;
      RST = 1'b1;
      bus.OPCODE = OP; bus.FUNC3 = 3'b000;
      bus.BR_EQ = 1'b0; bus.BR_LT = 1'b0; bus.BR_LTU = 1'b0;
      bus.INTR = 1'b0; bus.MIE = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick; #1;
         vectors++;
         if (obs !== O_ZERO) begin miscompares++; $display("FAIL reset_out[%0d]: got %b want %b", i, obs, O_ZERO); end
      end
      RST = 1'b0; #1;
      vectors++;
      if (obs !== O_FETCH) begin miscompares++; $display("FAIL reset_first_fetch: got %b want %b", obs, O_FETCH); end
      tick; #1;
      vectors++;
      if (obs !== O_EX0) begin miscompares++; $display("FAIL reset_op_exec: got %b want %b", obs, O_EX0); end
      tick; #1;
      vectors++;
      if (obs !== O_FETCH) begin miscompares++; $display("FAIL reset_op_refetch: got %b want %b", obs, O_FETCH); end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 8; i++) begin
         bus.OPCODE = b2b_op[i]; #1;
         vectors++;
         if (obs !== O_FETCH) begin miscompares++; $display("FAIL b2b_fetch[%0d]: got %b want %b", i, obs, O_FETCH); end
         tick; #1;
         vectors++;
         if (obs !== b2b_exp[i]) begin miscompares++; $display("FAIL b2b_exec[%0d]: got %b want %b", i, obs, b2b_exp[i]); end
         tick;
      end
   endtask

   task automatic test_branch;
      logic [2:0] f3;
      logic [2:0] fl;
      logic       tk;
      logic [7:0] want;
      for (int f = 0; f < 8; f++) begin
         if (f == 2 || f == 3) continue;
         for (int k = 0; k < 8; k++) begin
            f3 = 3'(f);
            fl = 3'(k);
            bus.OPCODE = BRANCH; bus.FUNC3 = f3;
            {bus.BR_EQ, bus.BR_LT, bus.BR_LTU} = fl;
            case (f3)
               3'b000:  tk = fl[2];
               3'b001:  tk = !fl[2];
               3'b100:  tk = fl[1];
               3'b101:  tk = !fl[1];
               3'b110:  tk = fl[0];
               default: tk = !fl[0];
            endcase
            want = tk ? O_EXBR : O_EX0;
            #1;
            vectors++;
            if (obs !== O_FETCH) begin miscompares++; $display("FAIL br_fetch f3=%b fl=%b: got %b want %b", f3, fl, obs, O_FETCH); end
            tick; #1;
            vectors++;
            if (obs !== want) begin miscompares++; $display("FAIL br_exec f3=%b fl=%b: got %b want %b", f3, fl, obs, want); end
            tick;
         end
      end
      bus.FUNC3 = 3'b000; {bus.BR_EQ, bus.BR_LT, bus.BR_LTU} = 3'b000;
   endtask

   task automatic test_load;
      bus.OPCODE = LOAD; #1;
      vectors++;
      if (obs !== O_FETCH) begin miscompares++; $display("FAIL load_fetch: got %b want %b", obs, O_FETCH); end
      tick; #1;
      vectors++;
      if (obs !== O_LDEX) begin miscompares++; $display("FAIL load_exec: got %b want %b", obs, O_LDEX); end
      tick; #1;
      vectors++;
      if (obs !== O_WB) begin miscompares++; $display("FAIL load_wb: got %b want %b", obs, O_WB); end
      tick; #1;
      vectors++;
      if (obs !== O_FETCH) begin miscompares++; $display("FAIL load_refetch: got %b want %b", obs, O_FETCH); end
   endtask

   task automatic test_intr_jal;
      bus.OPCODE = JAL; bus.INTR = 1'b1; bus.MIE = 1'b1; #1;
      vectors++;
      if (obs !== O_FETCH) begin miscompares++; $display("FAIL ijal_fetch: got %b want %b", obs, O_FETCH); end
      tick; bus.INTR = 1'b0; #1;
      vectors++;
      if (obs !== O_EXJAL) begin miscompares++; $display("FAIL ijal_exec: got %b want %b", obs, O_EXJAL); end
      tick; #1;
      vectors++;
      if (obs !== O_INTR) begin miscompares++; $display("FAIL ijal_intr: got %b want %b", obs, O_INTR); end
      tick; #1;
      vectors++;
      if (obs !== O_FETCH) begin miscompares++; $display("FAIL ijal_refetch: got %b want %b", obs, O_FETCH); end
      // Same request with MIE off must not divert.
      bus.INTR = 1'b1; bus.MIE = 1'b0; #1;
      tick; bus.INTR = 1'b0; #1;
      vectors++;
      if (obs !== O_EXJAL) begin miscompares++; $display("FAIL ijal_nomie_exec: got %b want %b", obs, O_EXJAL); end
      tick; #1;
      vectors++;
      if (obs !== O_FETCH) begin miscompares++; $display("FAIL ijal_nomie_fetch: got %b want %b", obs, O_FETCH); end
   endtask

   task automatic test_pending_rearm;
      bus.OPCODE = OP; bus.INTR = 1'b1; bus.MIE = 1'b1; #1;
      tick; #1;
      vectors++;
      if (obs !== O_EX0) begin miscompares++; $display("FAIL rearm_exec: got %b want %b", obs, O_EX0); end
      tick; #1;
      vectors++;
      if (obs !== O_INTR) begin miscompares++; $display("FAIL rearm_intr: got %b want %b", obs, O_INTR); end
      tick; bus.MIE = 1'b0; #1;
      vectors++;
      if (obs !== O_FETCH) begin miscompares++; $display("FAIL rearm_fetch1: got %b want %b", obs, O_FETCH); end
      tick; tick; #1;
      vectors++;
      if (obs !== O_FETCH) begin miscompares++; $display("FAIL rearm_masked: got %b want %b", obs, O_FETCH); end
      bus.MIE = 1'b1; #1;
      tick; #1;
      tick; bus.INTR = 1'b0; #1;
      vectors++;
      if (obs !== O_INTR) begin miscompares++; $display("FAIL rearm_reenabled: got %b want %b", obs, O_INTR); end
      tick; bus.MIE = 1'b0; #1;
   endtask

   task automatic test_load_intr_reset;
      bus.OPCODE = LOAD; bus.MIE = 1'b1; #1;
      tick; bus.INTR = 1'b1; #1;
      vectors++;
      if (obs !== O_LDEX) begin miscompares++; $display("FAIL ldi_exec: got %b want %b", obs, O_LDEX); end
      tick; bus.INTR = 1'b0; #1;
      vectors++;
      if (obs !== O_WB) begin miscompares++; $display("FAIL ldi_wb: got %b want %b", obs, O_WB); end
      tick; #1;
      vectors++;
      if (obs !== O_INTR) begin miscompares++; $display("FAIL ldi_intr: got %b want %b", obs, O_INTR); end
      tick; bus.MIE = 1'b0; #1;
      // Reset landing in ST_WB abandons the load without a PC write.
      tick; tick; RST = 1'b1; #1;
      vectors++;
      if (obs !== O_ZERO) begin miscompares++; $display("FAIL rst_in_wb: got %b want %b", obs, O_ZERO); end
      tick; RST = 1'b0; #1;
      vectors++;
      if (obs !== O_FETCH) begin miscompares++; $display("FAIL rst_after_wb: got %b want %b", obs, O_FETCH); end
   endtask

   task automatic test_illegal;
      logic [6:0] ops [2] = '{BADOP, BRANCH};
      bus.MIE = 1'b0; bus.FUNC3 = 3'b010;
      {bus.BR_EQ, bus.BR_LT, bus.BR_LTU} = 3'b111;
      for (int i = 0; i < 2; i++) begin
         bus.OPCODE = ops[i]; #1;
         tick; #1;
`ifdef ILLEGAL_TRAP_EN
         vectors++;
         if (obs !== O_TRAP) begin miscompares++; $display("FAIL ill_exec[%0d]: got %b want %b", i, obs, O_TRAP); end
         tick; #1;
         vectors++;
         if (obs !== O_INTR) begin miscompares++; $display("FAIL ill_intr[%0d]: got %b want %b", i, obs, O_INTR); end
`else
         vectors++;
         if (obs !== O_EX0) begin miscompares++; $display("FAIL ill_nop[%0d]: got %b want %b", i, obs, O_EX0); end
`endif
         tick; #1;
         vectors++;
         if (obs !== O_FETCH) begin miscompares++; $display("FAIL ill_fetch[%0d]: got %b want %b", i, obs, O_FETCH); end
      end
   endtask

   initial begin
      test_reset;
      test_back_to_back;
      test_branch;
      test_load;
      test_intr_jal;
      test_pending_rearm;
      test_load_intr_reset;
      test_illegal;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
